// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and owner encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int DEPTH     = 1024;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    localparam int GNT_CORE   = 0;
    localparam int GNT_LOADER = 1;

    typedef enum logic {
        OWN_CORE   = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational grant selection between core and loader with a loader burst limit.
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             i_c_req,
    input  logic             i_l_req,
    input  logic             i_boot_mode,
    input  logic [CNT_W-1:0] i_burst_cnt,
    output logic [1:0]       o_gnt
);

    logic w_c_ok;
    logic w_burst_full;

    assign w_c_ok       = i_c_req & ~i_boot_mode;
    assign w_burst_full = (i_burst_cnt == CNT_W'(MAX_BURST));

    always_comb begin
        o_gnt = 2'b00;
        if (w_c_ok && i_l_req) begin
            // Loader normally wins a conflict; the core gets one slot per full burst.
            if (w_burst_full) o_gnt[GNT_CORE]   = 1'b1;
            else              o_gnt[GNT_LOADER] = 1'b1;
        end else if (w_c_ok) begin
            o_gnt[GNT_CORE] = 1'b1;
        end else if (i_l_req) begin
            o_gnt[GNT_LOADER] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: grant, range check, RAM strobes and one-cycle response path.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH     = dmem_arbiter_pkg::DEPTH,
    parameter int ADDR_W    = dmem_arbiter_pkg::ADDR_W,
    parameter int DATA_W    = dmem_arbiter_pkg::DATA_W,
    parameter int MAX_BURST = dmem_arbiter_pkg::MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_mode,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              c_gnt,
    output logic              l_gnt,
    output logic              c_rvalid,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic [DATA_W-1:0] l_rdata,
    output logic              c_err,
    output logic              l_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    function automatic logic in_range(input logic [31:0] addr);
        return addr < 32'(DEPTH);
    endfunction

    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_resp_vld_p1;
    owner_e            r_resp_owner_p1;
    logic              r_resp_err_p1;
    logic              r_resp_is_load_p1;

    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_sel_core;
    logic [31:0]       w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;
    logic              w_access;
    logic              w_rsp;
    logic [DATA_W-1:0] w_rdata;

    dmem_rr_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .i_c_req     (c_req),
        .i_l_req     (l_req),
        .i_boot_mode (boot_mode),
        .i_burst_cnt (r_burst_cnt),
        .o_gnt       (w_pick)
    );

    // p0: grant, select and range check in the request cycle
    assign w_gnt      = w_pick & {2{rst_n}};
    assign w_any      = |w_gnt;
    assign w_sel_core = w_gnt[GNT_CORE];
    assign w_addr     = w_sel_core ? c_addr  : l_addr;
    assign w_we       = w_sel_core ? c_we    : l_we;
    assign w_wdata    = w_sel_core ? c_wdata : l_wdata;
    assign w_in_range = in_range(w_addr);
    assign w_access   = w_any & w_in_range;

    assign c_gnt     = w_gnt[GNT_CORE];
    assign l_gnt     = w_gnt[GNT_LOADER];
    assign mem_en    = w_access;
    assign mem_we    = w_access & w_we;
    assign mem_addr  = w_access ? w_addr[ADDR_W-1:0] : '0;
    assign mem_wdata = w_access ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (!c_req || w_gnt[GNT_CORE]) begin
            r_burst_cnt <= '0;
        end else if (w_gnt[GNT_LOADER] && !boot_mode &&
                     r_burst_cnt != CNT_W'(MAX_BURST)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    // p1: response registers, one cycle behind the grant
    always_ff @(posedge clk) begin
        if (!rst_n) r_resp_vld_p1 <= 1'b0;
        else        r_resp_vld_p1 <= w_any;
    end

    always_ff @(posedge clk) begin
        r_resp_owner_p1   <= w_sel_core ? OWN_CORE : OWN_LOADER;
        r_resp_err_p1     <= ~w_in_range;
        r_resp_is_load_p1 <= ~w_we;
    end

    assign w_rsp   = r_resp_vld_p1 & rst_n;
    assign w_rdata = (r_resp_is_load_p1 && !r_resp_err_p1) ? mem_rdata : '0;

    assign c_rvalid = w_rsp & (r_resp_owner_p1 == OWN_CORE);
    assign l_rvalid = w_rsp & (r_resp_owner_p1 == OWN_LOADER);
    assign c_err    = c_rvalid & r_resp_err_p1;
    assign l_err    = l_rvalid & r_resp_err_p1;
    assign c_rdata  = c_rvalid ? w_rdata : '0;
    assign l_rdata  = l_rvalid ? w_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a response scoreboard and a write-first RAM model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_mode = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;
    logic        c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, mem_en, mem_we;
    logic [31:0] c_rdata, l_rdata, mem_wdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram    [0:1023];
    logic [31:0] shadow [0:1023];

    typedef struct packed {
        logic        rn, boot, cr, cwe;
        logic [31:0] ca, cd;
        logic        lr, lwe;
        logic [31:0] la, ld;
        logic        ecg, elg, een;
    } vec_t;

    typedef struct packed {
        logic        owner;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
        end
    end

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .c_gnt(c_gnt), .l_gnt(l_gnt), .c_rvalid(c_rvalid), .l_rvalid(l_rvalid),
        .c_rdata(c_rdata), .l_rdata(l_rdata), .c_err(c_err), .l_err(l_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic vec_t mk(input logic rn, input logic boot,
                                input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cd,
                                input logic lr, input logic lwe, input logic [31:0] la, input logic [31:0] ld,
                                input logic ecg, input logic elg, input logic een);
        vec_t v;
        v.rn = rn; v.boot = boot; v.cr = cr; v.cwe = cwe; v.ca = ca; v.cd = cd;
        v.lr = lr; v.lwe = lwe; v.la = la; v.ld = ld;
        v.ecg = ecg; v.elg = elg; v.een = een;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t        e;
        logic [31:0] a, d;
        logic        we, inr;
        rst_n = v.rn; boot_mode = v.boot;
        c_req = v.cr; c_we = v.cwe; c_addr = v.ca; c_wdata = v.cd;
        l_req = v.lr; l_we = v.lwe; l_addr = v.la; l_wdata = v.ld;
        @(negedge clk);
        if (!v.rn) begin
            chk({tag, "_rst_ctl"}, 32'({c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, mem_en, mem_we}), 32'd0);
            chk({tag, "_rst_data"}, c_rdata | l_rdata | mem_wdata | 32'(mem_addr), 32'd0);
            sbq.delete();
        end else begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.owner == 1'b0) begin
                    chk({tag, "_rvalid"}, 32'({c_rvalid, l_rvalid}), 32'd2);
                    chk({tag, "_c_err"}, 32'(c_err), 32'(e.err));
                    chk({tag, "_c_rdata"}, c_rdata, e.rdata);
                end else begin
                    chk({tag, "_rvalid"}, 32'({c_rvalid, l_rvalid}), 32'd1);
                    chk({tag, "_l_err"}, 32'(l_err), 32'(e.err));
                    chk({tag, "_l_rdata"}, l_rdata, e.rdata);
                end
            end else begin
                chk({tag, "_no_rvalid"}, 32'({c_rvalid, l_rvalid}), 32'd0);
            end
            chk({tag, "_gnt"}, 32'({c_gnt, l_gnt}), 32'({v.ecg, v.elg}));
            chk({tag, "_mem_en"}, 32'(mem_en), 32'(v.een));
            if (v.ecg || v.elg) begin
                a   = v.ecg ? v.ca : v.la;
                d   = v.ecg ? v.cd : v.ld;
                we  = v.ecg ? v.cwe : v.lwe;
                inr = (a < 32'd1024);
                if (inr) begin
                    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(a[9:0]));
                    chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
                    if (we) chk({tag, "_mem_wdata"}, mem_wdata, d);
                end else begin
                    chk({tag, "_mem_we_oor"}, 32'(mem_we), 32'd0);
                end
                e.owner = v.ecg ? 1'b0 : 1'b1;
                e.err   = !inr;
                e.rdata = (inr && !we) ? shadow[a[9:0]] : 32'd0;
                sbq.push_back(e);
                if (inr && we) shadow[a[9:0]] = d;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = 32'd0;
            shadow[i] = 32'd0;
        end

        // reset with both masters requesting, then basic accesses and range edges
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0, 1,0,32'd5,0, 1,0,32'd100,0, 0,0,0));
        tbl.push_back(mk(1,0, 1,1,32'd5,32'hDEAD_BEEF, 1,0,32'd100,0, 0,1,1));
        tbl.push_back(mk(1,0, 1,1,32'd5,32'hDEAD_BEEF, 0,0,0,0,       1,0,1));
        tbl.push_back(mk(1,0, 1,0,32'd5,0,             0,0,0,0,       1,0,1));
        tbl.push_back(mk(1,0, 0,0,0,0,     1,1,32'd7,32'h1234_5678,   0,1,1));
        tbl.push_back(mk(1,0, 1,0,32'd7,0,             0,0,0,0,       1,0,1));
        tbl.push_back(mk(1,0, 1,0,32'd1023,0,          0,0,0,0,       1,0,1));
        tbl.push_back(mk(1,0, 1,0,32'd1024,0,          0,0,0,0,       1,0,0));
        tbl.push_back(mk(1,0, 1,0,32'hFFFF_FFFF,0,     0,0,0,0,       1,0,0));
        tbl.push_back(mk(1,0, 1,1,32'hFFFF_FFFF,32'h0BAD_0BAD, 0,0,0,0, 1,0,0));
        tbl.push_back(mk(1,0, 1,0,32'd0,0,             0,0,0,0,       1,0,1));
        tbl.push_back(mk(1,0, 0,0,0,0,     1,0,32'd1024,0,            0,1,0));
        tbl.push_back(mk(1,0, 0,0,0,0,     0,0,0,0,                   0,0,0));
        // fairness: L,L,L,L,C twice
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1,0, 1,0,32'd5,0, 1,0,32'(200+i),0, (i%5==4),(i%5!=4),1));
        // boot mode blocks the core entirely
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1,1, 1,0,32'd5,0, 1,0,32'(300+i),0, 0,1,1));
        // boot mode released: core within MAX_BURST+1 grants
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1,0, 1,0,32'd7,0, 1,0,32'(400+i),0, (i==4),(i!=4),1));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

        // reset mid-operation: the pending load response is dropped, burst count restarts
        apply(mk(1,0, 1,0,32'd5,0, 1,0,32'd500,0, 0,1,1), "mid_l0");
        apply(mk(1,0, 1,0,32'd5,0, 1,0,32'd501,0, 0,1,1), "mid_l1");
        apply(mk(0,0, 1,0,32'd5,0, 1,0,32'd502,0, 0,0,0), "mid_rst");
        for (int i = 0; i < 5; i++)
            apply(mk(1,0, 1,0,32'd5,0, 1,0,32'(600+i),0, (i==4),(i!=4),1), $sformatf("post_rst%0d", i));
        apply(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0), "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port 1024-word data memory, shared between the core load/store path and the program loader/debug port. It accepts word-address requests from both masters and grants at most one per cycle. It range-checks each request against the memory depth and answers out-of-range requests with an error instead of accessing memory. It also drives the RAM enable/write strobes and returns exactly one response per granted request, one cycle after the grant.

## Interface
- DEPTH, 1024: memory words; legal addresses 0..DEPTH-1
- ADDR_W, 10: RAM address width, log2(DEPTH)
- DATA_W, 32: data width
- MAX_BURST, 4: consecutive loader grants allowed while core waits

- clk  in  1  clock; single clock domain, everything on rising edge
- rst_n  in  1  reset, synchronous, active-low
- boot_mode  in  1  1: core port blocked, loader only
- c_req / l_req  in  1  core / loader request, held until granted
- c_we / l_we  in  1  1 = store, 0 = load
- c_addr / l_addr  in  32  full word address (rs1+imm sum for core)
- c_wdata / l_wdata  in  DATA_W  store data
- c_gnt / l_gnt  out  1  request accepted this cycle
- c_rvalid / l_rvalid  out  1  response pulse, one cycle after grant
- c_rdata / l_rdata  out  DATA_W  load data, valid with rvalid
- c_err / l_err  out  1  address out of range, valid with rvalid
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one-cycle latency after mem_en

## Operation
- Arbitration per cycle, combinational grant:
  - only one requester asserting req: it wins, except core is never granted while boot_mode=1
  - both asserting: loader wins unless burst_cnt == MAX_BURST and boot_mode=0, in which case core wins
- burst_cnt (0..MAX_BURST) update on each grant:
  - loader granted while c_req=1 and boot_mode=0: increment, saturating
  - core granted: clear
  - c_req=0: clear
- Range check on the granted address: in range iff addr < DEPTH, compared on the full 32 bits.
- Granted in range: mem_en=1, mem_we=we, mem_addr=addr[ADDR_W-1:0], mem_wdata=wdata, all in the grant cycle.
- Granted out of range: mem_en=0, mem_we=0, no RAM side effect.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Response registers: resp_valid, resp_owner, resp_err, resp_is_load, loaded at each grant.
- Next cycle the owner's rvalid=1, err=resp_err.
- rdata = mem_rdata only for an in-range load; 0 for stores and errors.
- Non-owner rdata/err/rvalid = 0.
- Stores also produce an rvalid acknowledge.
- Fully pipelined: a new grant may occur in the same cycle a previous response is returned, giving back-to-back throughput of 1 access per cycle.

## Timing
- Reset (rst_n=0 at clock edge): resp_valid=0, burst_cnt=0.
- While rst_n=0, all gnt/rvalid/err/mem_en/mem_we outputs = 0 and all data outputs = 0.
- A response pending at reset is dropped; no grant is issued in any cycle where rst_n=0.
- Latency: grant in cycle N, response in N+1, for loads, stores and errors alike.
- Requester may change its address/data or deassert req in the cycle after gnt.
- A request deasserted before grant is never serviced.
- Boundary behaviour:
  - addr = DEPTH-1 is legal
  - addr = DEPTH gives err=1
  - addr = 32'hFFFF_FFFF gives err=1; no truncation aliasing to address 0
- Write then read of the same address on consecutive grants returns the new data, because the RAM is write-first per word.
- boot_mode falling while a loader burst is in progress: the fairness rule applies from that cycle on.

## Structure
- Shared package holds DEPTH, ADDR_W, DATA_W and the owner encoding (OWN_CORE=0, OWN_LOADER=1).
- Sub-module `dmem_rr_pick`: pure combinational grant logic (reqs, boot_mode, burst_cnt in; grant vector out).
- Counter, range check and response registers live in the top module.

## Test plan
- Reset: hold rst_n=0 with both req high, then release -> no gnt during reset; first post-reset cycle grants the loader; c_rvalid=l_rvalid=0 throughout reset.
- Core store then load: store 32'hDEAD_BEEF to 5, then load 5 -> c_gnt each cycle, c_rvalid on following cycles, load response c_rdata=32'hDEAD_BEEF, c_err=0.
- Range: core load at addresses 1023, 1024 and 32'hFFFF_FFFF -> 1023: mem_en=1, err=0; 1024 and FFFF_FFFF: mem_en=0, c_err=1, c_rdata=0.
- Fairness: both req continuously, boot_mode=0, MAX_BURST=4 -> grant pattern L,L,L,L,C repeating.
- Boot mode: both req, boot_mode=1 for 10 cycles -> 10 loader grants, zero core grants; boot_mode dropped -> core granted within MAX_BURST+1 cycles.
- Reset mid-operation: load granted, rst_n=0 on the next edge -> no rvalid pulse; burst_cnt restarts at 0.
